// File: rtl/spi_slave_if.sv
// Bus between the SPI slave front end and its RAM/SPI peers.
// The slave modport is the SPI-slave side; master is the SPI host plus the RAM.
interface spi_slave_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave  (input  SS_n, MOSI, tx_data, tx_valid,
                  output MISO, rx_data, rx_valid);
  modport master (output SS_n, MOSI, tx_data, tx_valid,
                  input  MISO, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit command words for the RAM and, on read-data
// frames, serialises the RAM's response byte back out on MISO.
module spi_slave #(
  parameter int TX_TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_slave_if.slave   bus
);

  localparam int WW = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, RD_WAIT, RD_SHIFT, HOLD
  } state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [8:0]  rx_sh, rx_sh_d;
  logic [6:0]  tx_sh, tx_sh_d;
  logic [9:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        miso_q, miso_d;
  logic        rd_addr_done, rd_addr_done_d;
  logic        rx_state;

  assign rx_state     = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      wcnt         <= '0;
      rx_sh        <= '0;
      tx_sh        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      miso_q       <= 1'b0;
      rd_addr_done <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      wcnt         <= wcnt_d;
      rx_sh        <= rx_sh_d;
      tx_sh        <= tx_sh_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      miso_q       <= miso_d;
      rd_addr_done <= rd_addr_done_d;
    end
  end

  // Deselect wins over everything outside IDLE.
  always_comb begin
    state_d = state;
    if (state != IDLE && bus.SS_n) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:      if (!bus.SS_n) state_d = CHK_CMD;
        CHK_CMD:   state_d = !bus.MOSI   ? WRITE :
                             rd_addr_done ? READ_DATA : READ_ADD;
        WRITE,
        READ_ADD:  if (cnt == 4'd9) state_d = HOLD;
        READ_DATA: if (cnt == 4'd9) state_d = RD_WAIT;
        RD_WAIT:   if (bus.tx_valid) state_d = RD_SHIFT;
                   else if (wcnt == W_LAST) state_d = HOLD;
        RD_SHIFT:  if (cnt == 4'd7) state_d = HOLD;
        HOLD:      state_d = HOLD;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d          = cnt;
    wcnt_d         = '0;
    rx_sh_d        = rx_sh;
    tx_sh_d        = tx_sh;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    rd_addr_done_d = rd_addr_done;

    if (state_d != state)
      cnt_d = '0;
    else if (rx_state || state == RD_SHIFT)
      cnt_d = cnt + 4'd1;

    if (state == RD_WAIT && state_d == RD_WAIT)
      wcnt_d = wcnt + 1'b1;

    if (!bus.SS_n) begin
      if (rx_state) begin
        rx_sh_d = {rx_sh[7:0], bus.MOSI};
        if (cnt == 4'd9) begin
          rx_valid_d = 1'b1;
          rx_data_d  = {rx_sh, bus.MOSI};
          if (state == READ_ADD)  rd_addr_done_d = 1'b1;
          if (state == READ_DATA) rd_addr_done_d = 1'b0;
        end
      end
      // MSB goes out the cycle after capture; the rest trails from tx_sh.
      if (state == RD_WAIT && bus.tx_valid) begin
        miso_d  = bus.tx_data[7];
        tx_sh_d = bus.tx_data[6:0];
      end
      if (state == RD_SHIFT && cnt != 4'd7) begin
        miso_d  = tx_sh[6];
        tx_sh_d = {tx_sh[5:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed + randomized frames for spi_slave, checked per cycle against a
// frame-level model of rx pulses, MISO bytes and the read-address flag.
module tb_spi_slave;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_if bus();
  spi_slave #(.TX_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  bit         rd_done = 1'b0;
  logic [9:0] cur_rxd = '0;

  task automatic chk(input string tag, input int k, input logic [9:0] got, input logic [9:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'($urandom);
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_rxv",  i, {9'b0, bus.rx_valid}, 10'd0);
      chk("idle_miso", i, {9'b0, bus.MISO}, 10'd0);
      chk("idle_rxd",  i, bus.rx_data, cur_rxd);
    end
  endtask

  // ab: data bits sent before SS_n rises (10 = complete frame, SS_n rises at edge len).
  // tx_k: edge index where a read frame sees tx_valid. rst_k: edge after which reset pulses.
  task automatic frame(input bit sel, input logic [9:0] d, input int ab, input int tx_k,
                       input logic [7:0] txd, input int len, input int rst_k);
    bit         full;
    int         L, cap;
    bit         exp_m;
    full = (ab >= 10);
    L    = full ? len : 2 + ab;
    cap  = 0;
    if (full && sel && rd_done && tx_k >= 12 && tx_k <= 11 + T && tx_k < L) cap = tx_k;
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      bus.SS_n     = (k == L);
      bus.MOSI     = (k == 1) ? sel : (k >= 2 && k <= 11) ? d[11-k] : 1'($urandom);
      bus.tx_valid = sel ? (k == tx_k) : 1'($urandom);
      bus.tx_data  = (k == tx_k) ? txd : 8'($urandom);
      @(posedge clk); #1;
      if (full && k == 11) cur_rxd = d;
      exp_m = (cap > 0 && k >= cap && k < cap + 8 && k < L) ? txd[7-(k-cap)] : 1'b0;
      chk("rxv",  k, {9'b0, bus.rx_valid}, {9'b0, (full && k == 11)});
      chk("rxd",  k, bus.rx_data, cur_rxd);
      chk("miso", k, {9'b0, bus.MISO}, {9'b0, exp_m});
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_miso", k, {9'b0, bus.MISO}, 10'd0);
        chk("rst_rxv",  k, {9'b0, bus.rx_valid}, 10'd0);
        chk("rst_rxd",  k, bus.rx_data, 10'd0);
        rd_done = 1'b0;
        cur_rxd = '0;
        @(negedge clk);
        bus.SS_n = 1'b1;
        rst_n    = 1'b1;
        return;
      end
    end
    if (full && sel) rd_done = !rd_done;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rxv",  0, {9'b0, bus.rx_valid}, 10'd0);
    chk("reset_rxd",  0, bus.rx_data, 10'd0);
    chk("reset_miso", 0, {9'b0, bus.MISO}, 10'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // write address then data, one idle cycle between frames
    frame(1'b0, 10'h0A5, 10, 0, 8'h00, 12, -1);
    frame(1'b0, 10'h13C, 10, 0, 8'h00, 12, -1);
    idle(2);

    // read pair
    frame(1'b1, 10'h2A5, 10, 12, 8'hC3, 22, -1);
    frame(1'b1, 10'h300, 10, 12, 8'hC3, 22, -1);
    idle(1);

    // abort after d5, next read still addresses
    frame(1'b1, 10'h155, 5, 0, 8'h00, 0, -1);
    frame(1'b1, 10'($urandom), 10, 12, 8'h5A, 22, -1);

    // timeout, then next read addresses again
    frame(1'b1, 10'($urandom), 10, 11 + T + 1, 8'hFF, 24, -1);
    frame(1'b1, 10'($urandom), 10, 12, 8'hFF, 22, -1);
    // capture at the last edge of the wait window
    frame(1'b1, 10'($urandom), 10, 11 + T, 8'h81, 26, -1);
    // abort mid-MISO shift
    frame(1'b1, 10'($urandom), 10, 12, 8'h00, 12, -1);
    frame(1'b1, 10'($urandom), 10, 12, 8'hFF, 15, -1);
    idle(1);

    for (int n = 0; n < 40; n++) begin
      frame(1'($urandom), 10'($urandom),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10,
            int'($urandom_range(12, 11 + T + 1)), 8'($urandom),
            int'($urandom_range(12, 24)), -1);
      idle(int'($urandom_range(0, 2)));
    end

    // async reset in the middle of a MISO byte
    if (!rd_done) frame(1'b1, 10'($urandom), 10, 12, 8'h00, 12, -1);
    frame(1'b1, 10'h3F0, 10, 12, 8'hFF, 22, 15);
    idle(2);
    frame(1'b1, 10'h0F0, 10, 12, 8'hA5, 22, -1);
    frame(1'b1, 10'h1F0, 10, 12, 8'hA5, 22, -1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
